// File: rtl/bus_cycle_arbiter_pkg.sv
// bus_cycle_pkg: FSM state encoding and timeout constant shared by bus_cycle_arbiter
package bus_cycle_pkg;
  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    T1   = 6'b000010,
    T2   = 6'b000100,
    T3   = 6'b001000,
    TW   = 6'b010000,
    T4   = 6'b100000
  } state_t;
  localparam int TIMEOUT_CYCLES = 15;
endpackage

// File: rtl/bus_cycle_arbiter_if.sv
// bus_cycle_arbiter_if: requester handshake plus memory/IO slave bus of bus_cycle_arbiter
interface bus_cycle_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic [1:0]            REQ, REQ_WE, REQ_IO, GNT, DONE;
  logic [ADDR_WIDTH-1:0] REQ_ADDR0, REQ_ADDR1, ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA0, REQ_WDATA1, RDATA, AD_OUT, BUS_DATA;
  logic                  ALE, RD_N, WR_N, IOM, AD_OE, READY, ERR;
  modport master (
    input  REQ, REQ_WE, REQ_IO, REQ_ADDR0, REQ_ADDR1, REQ_WDATA0, REQ_WDATA1, BUS_DATA, READY,
    output GNT, DONE, RDATA, ALE, RD_N, WR_N, IOM, ADDR, AD_OUT, AD_OE, ERR
  );
  modport slave (
    output REQ, REQ_WE, REQ_IO, REQ_ADDR0, REQ_ADDR1, REQ_WDATA0, REQ_WDATA1, BUS_DATA, READY,
    input  GNT, DONE, RDATA, ALE, RD_N, WR_N, IOM, ADDR, AD_OUT, AD_OE, ERR
  );
endinterface

// File: rtl/bus_cycle_arbiter_rr.sv
// rr_arbiter2: two-way pick; on a tie the requester not served last wins
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);
  logic last_q;
  always_comb gnt_o = &req_i ? (last_q ? 2'b01 : 2'b10) : req_i;
  // reset to 1 so requester 0 takes the first tie
  always_ff @(posedge clk) last_q <= rst ? 1'b1 : update_i ? gnt_o[1] : last_q;
endmodule

// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter: two-requester T1..T4 bus cycle engine with ALE/RD_N/WR_N strobes.
// Define BUS_TIMEOUT_EN to end wait states after TIMEOUT_CYCLES TW cycles with an ERR pulse.
module bus_cycle_arbiter
  import bus_cycle_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input logic CLK,
  input logic RESET,
  bus_cycle_arbiter_if.master bus
);
  state_t                state_q, state_d;
  logic [1:0]            gnt_q, done_q, req_eff, win;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic                  we_q, io_q, ale_q, rd_n_q, wr_n_q, ad_oe_q;
  logic                  arb, go, data_ph, rdy_end, to_hit, leave, strobe_d;
  // the owner finishing in T4 is masked so the other side gets the next cycle
  assign arb     = state_q == IDLE || state_q == T4;
  assign req_eff = bus.REQ & ~(state_q == T4 ? gnt_q : 2'b00);
  assign go      = arb && |req_eff;
  assign data_ph = state_q == T3 || state_q == TW;
  assign rdy_end = data_ph && bus.READY;
  assign leave   = rdy_end || to_hit;
  always_comb begin
    state_d  = go ? T1 : arb ? IDLE : state_q == T1 ? T2 : state_q == T2 ? T3 : data_ph ? (leave ? T4 : TW) : IDLE;
    strobe_d = state_d inside {T2, T3, TW};
  end
  rr_arbiter2 u_rr (.clk(CLK), .rst(RESET), .req_i(req_eff), .update_i(go), .gnt_o(win));
`ifdef BUS_TIMEOUT_EN
  logic [3:0] tw_cnt_q;
  logic       err_q;
  assign to_hit = state_q == TW && tw_cnt_q == 4'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLK) begin
    tw_cnt_q <= (RESET || state_q != TW) ? 4'd0 : tw_cnt_q + 4'd1;
    err_q    <= !RESET && to_hit;
  end
  assign bus.ERR = err_q;
`else
  assign to_hit  = 1'b0;
  assign bus.ERR = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      ale_q   <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      ad_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= go ? win : state_d == IDLE ? 2'b00 : gnt_q;
      if (go) begin
        we_q    <= bus.REQ_WE[win[1]];
        io_q    <= bus.REQ_IO[win[1]];
        addr_q  <= win[1] ? bus.REQ_ADDR1 : bus.REQ_ADDR0;
        wdata_q <= win[1] ? bus.REQ_WDATA1 : bus.REQ_WDATA0;
      end
      ale_q   <= state_d == T1;
      rd_n_q  <= !(strobe_d && !we_q);
      wr_n_q  <= !(strobe_d && we_q);
      ad_oe_q <= we_q && !(state_d inside {IDLE, T1});
      done_q  <= state_d == T4 ? gnt_q : 2'b00;
      rdata_q <= to_hit ? '1 : (rdy_end && !we_q) ? bus.BUS_DATA : rdata_q;
    end
  end
  assign bus.GNT    = gnt_q;
  assign bus.DONE   = done_q;
  assign bus.RDATA  = rdata_q;
  assign bus.ALE    = ale_q;
  assign bus.RD_N   = rd_n_q;
  assign bus.WR_N   = wr_n_q;
  assign bus.IOM    = io_q;
  assign bus.ADDR   = addr_q;
  assign bus.AD_OUT = wdata_q;
  assign bus.AD_OE  = ad_oe_q;
endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// tb_bus_cycle_arbiter: directed bench with a cycle-count transaction model of bus_cycle_arbiter
module tb_bus_cycle_arbiter;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  bus_cycle_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) bus ();
  bus_cycle_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  logic [7:0] smem [2][1024];
  logic [7:0] mmem [2][1024];
  assign bus.BUS_DATA = smem[bus.IOM][bus.ADDR];
  // model: a transaction occupies cycles k=0..3+w (T1, T2, T3, w waits, T4)
  bit busy, m_we, m_io, m_to, last, hold, chk_en;
  int k, w, owner, waits;
  logic [9:0] m_addr;
  logic [7:0] m_wdata, m_rdata;
  int tests, fails, nale, nrd, nwr;
  logic [1:0] d;
  int c;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic model_step(input logic [1:0] req, input logic rst);
    logic [1:0] cand;
    cand = req;
    if (rst) begin
      busy = 0;
      last = 1;
      m_rdata = '0;
    end else begin
      if (busy && k < 3 + w) begin
        k++;
        if (k == 3 + w) begin
          if (m_we) mmem[m_io][m_addr] = m_wdata;
          else m_rdata = m_to ? 8'hFF : mmem[m_io][m_addr];
        end
        cand = 2'b00;
      end else if (busy) begin
        busy = 0;
        cand[owner] = 1'b0;
      end
      if (cand != 2'b00) begin
        owner = (cand == 2'b11) ? int'(!last) : int'(cand[1]);
        last = owner[0];
        busy = 1;
        k = 0;
        m_we = bus.REQ_WE[owner];
        m_io = bus.REQ_IO[owner];
        m_addr = (owner == 1) ? bus.REQ_ADDR1 : bus.REQ_ADDR0;
        m_wdata = (owner == 1) ? bus.REQ_WDATA1 : bus.REQ_WDATA0;
        m_to = TO_EN && waits >= 15;
        w = m_to ? 15 : waits;
      end
    end
  endtask
  task automatic tick();
    logic [1:0] req_s;
    logic rst_s, strobe, fin;
    logic [1:0] oh;
    if (bus.WR_N === 1'b0 && bus.READY === 1'b1) smem[bus.IOM][bus.ADDR] = bus.AD_OUT;
    req_s = bus.REQ;
    rst_s = RESET;
    @(posedge CLK);
    #1;
    model_step(req_s, rst_s);
    if (chk_en && !hold) bus.REQ = bus.REQ & ~bus.DONE;
    bus.READY = !busy || k >= 2 + waits;
    if (chk_en) begin
      oh = busy ? 2'(1 << owner) : 2'b00;
      strobe = busy && k >= 1 && k <= 2 + w;
      fin = busy && k == 3 + w;
      chk("GNT", 32'(bus.GNT), 32'(oh));
      chk("DONE", 32'(bus.DONE), 32'(fin ? oh : 2'b00));
      chk("ALE", 32'(bus.ALE), 32'(busy && k == 0));
      chk("RD_N", 32'(bus.RD_N), 32'(!(strobe && !m_we)));
      chk("WR_N", 32'(bus.WR_N), 32'(!(strobe && m_we)));
      chk("AD_OE", 32'(bus.AD_OE), 32'(busy && m_we && k >= 1));
      chk("ERR", 32'(bus.ERR), 32'(fin && m_to));
      chk("RDATA", 32'(bus.RDATA), 32'(m_rdata));
      if (busy) begin
        chk("ADDR", 32'(bus.ADDR), 32'(m_addr));
        chk("IOM", 32'(bus.IOM), 32'(m_io));
      end
      if (busy && m_we && k >= 1) chk("AD_OUT", 32'(bus.AD_OUT), 32'(m_wdata));
      nale += int'(bus.ALE);
      nrd += int'(!bus.RD_N);
      nwr += int'(!bus.WR_N);
    end
  endtask
  task automatic run_done(input string n, input int c0, input int exp, output logic [1:0] dn, output int ce);
    ce = c0;
    dn = 2'b00;
    for (int i = 0; i < 40; i++) begin
      tick();
      ce++;
      if (bus.DONE != 2'b00) begin
        dn = bus.DONE;
        break;
      end
    end
    chk(n, ce, exp);
  endtask
  initial begin
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 1024; a++) begin
        smem[s][a] = 8'h00;
        mmem[s][a] = 8'h00;
      end
    smem[1][3] = 8'h3C;
    mmem[1][3] = 8'h3C;
    bus.REQ = 2'b00;
    bus.REQ_WE = 2'b00;
    bus.REQ_IO = 2'b00;
    bus.REQ_ADDR0 = '0;
    bus.REQ_ADDR1 = '0;
    bus.REQ_WDATA0 = '0;
    bus.REQ_WDATA1 = '0;
    bus.READY = 1'b1;
    busy = 0; last = 1; waits = 0; hold = 0; chk_en = 0; m_rdata = '0;
    tests = 0; fails = 0;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    chk_en = 1;
    chk("rst_gnt", 32'(bus.GNT), 0);
    chk("rst_rd_n", 32'(bus.RD_N), 1);
    chk("rst_wr_n", 32'(bus.WR_N), 1);
    chk("rst_addr", 32'(bus.ADDR), 0);
    chk("rst_ad_out", 32'(bus.AD_OUT), 0);
    chk("rst_rdata", 32'(bus.RDATA), 0);
    // memory write from requester 0
    bus.REQ_WE = 2'b01; bus.REQ_IO = 2'b00; bus.REQ_ADDR0 = 10'h155; bus.REQ_WDATA0 = 8'hA5;
    bus.REQ = 2'b01;
    nale = 0; nwr = 0; nrd = 0;
    tick();
    chk("wr_ale_first", 32'(bus.ALE), 1);
    run_done("wr_latency", 2, 5, d, c);
    chk("wr_done", 32'(d), 32'h1);
    chk("wr_wr_low_cycles", nwr, 2);
    chk("wr_ale_cycles", nale, 1);
    tick();
    chk("wr_slave_mem", 32'(smem[0][10'h155]), 32'hA5);
    // IO read from requester 1 with three wait states
    waits = 3;
    bus.REQ_WE = 2'b00; bus.REQ_IO = 2'b10; bus.REQ_ADDR1 = 10'h003;
    bus.REQ = 2'b10;
    nrd = 0;
    run_done("io_rd_latency", 1, 8, d, c);
    chk("io_rd_done", 32'(d), 32'h2);
    chk("io_rd_rdata", 32'(bus.RDATA), 32'h3C);
    chk("io_rd_rd_low_cycles", nrd, 5);
    waits = 0;
    tick();
    // both requesters held: alternate back-to-back
    hold = 1;
    bus.REQ_WE = 2'b01; bus.REQ_IO = 2'b00; bus.REQ_ADDR0 = 10'h020; bus.REQ_WDATA0 = 8'h11; bus.REQ_ADDR1 = 10'h155;
    bus.REQ = 2'b11;
    c = 1;
    for (int i = 0; i < 4; i++) begin
      run_done($sformatf("rr_latency%0d", i), c, 5 + 4 * i, d, c);
      chk($sformatf("rr_owner%0d", i), 32'(d), (i % 2 == 1) ? 32'h2 : 32'h1);
    end
    chk("rr_rdata", 32'(bus.RDATA), 32'hA5);
    bus.REQ = 2'b00;
    hold = 0;
    tick();
    chk("rr_idle_gnt", 32'(bus.GNT), 0);
    // request pulsed before grant is ignored
    bus.REQ_WE = 2'b01; bus.REQ_ADDR0 = 10'h200; bus.REQ_WDATA0 = 8'h5A;
    bus.REQ = 2'b01;
    tick();
    tick();
    bus.REQ = 2'b11;
    tick();
    bus.REQ = 2'b01;
    run_done("pulse_latency", 4, 5, d, c);
    chk("pulse_done", 32'(d), 32'h1);
    tick();
    chk("pulse_no_grant", 32'(bus.GNT), 0);
    chk("pulse_no_ale", 32'(bus.ALE), 0);
    // request dropped after grant still completes
    bus.REQ_WE = 2'b00; bus.REQ_IO = 2'b00; bus.REQ_ADDR1 = 10'h200;
    bus.REQ = 2'b10;
    tick();
    bus.REQ = 2'b00;
    run_done("drop_latency", 2, 5, d, c);
    chk("drop_done", 32'(d), 32'h2);
    chk("drop_rdata", 32'(bus.RDATA), 32'h5A);
    tick();
    // reset while in a wait state
    waits = 1000;
    bus.REQ_ADDR0 = 10'h155;
    bus.REQ = 2'b01;
    repeat (5) tick();
    chk("tw_rd_low", 32'(bus.RD_N), 0);
    RESET = 1'b1;
    bus.REQ = 2'b00;
    tick();
    chk("rst_tw_rd_n", 32'(bus.RD_N), 1);
    chk("rst_tw_wr_n", 32'(bus.WR_N), 1);
    chk("rst_tw_gnt", 32'(bus.GNT), 0);
    chk("rst_tw_done", 32'(bus.DONE), 0);
    RESET = 1'b0;
    waits = 0;
    tick();
    bus.REQ = 2'b11;
    run_done("post_rst_latency0", 1, 5, d, c);
    chk("post_rst_first", 32'(d), 32'h1);
    run_done("post_rst_latency1", c, 9, d, c);
    chk("post_rst_second", 32'(d), 32'h2);
    tick();
    // READY stuck low
    waits = 1000;
    bus.REQ_ADDR0 = 10'h155;
    bus.REQ = 2'b01;
`ifdef BUS_TIMEOUT_EN
    run_done("timeout_latency", 1, 20, d, c);
    chk("timeout_done", 32'(d), 32'h1);
    chk("timeout_err", 32'(bus.ERR), 1);
    chk("timeout_rdata", 32'(bus.RDATA), 32'hFF);
    tick();
`else
    repeat (30) tick();
    chk("stuck_rd_low", 32'(bus.RD_N), 0);
    chk("stuck_no_done", 32'(bus.DONE), 0);
    RESET = 1'b1;
    bus.REQ = 2'b00;
    tick();
    RESET = 1'b0;
`endif
    waits = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
